// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard display path: converter FSM states,
// digit/BCD sizes and the 7-segment pattern table ({g,f,e,d,c,b,a}, active-high).
package placar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV1  = 2'd1,
        ST_CONV2  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 12;
    localparam int BIN_W      = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/placar_bin2bcd.sv
// Sequential 7-bit double-dabble: the start clock performs step 1, six more clocks follow.
// done pulses in the clock where bcd holds the finished result.
module placar_bin2bcd
    import placar_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [BCD_W+BIN_W-1:0] sr_q, sr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;

    function automatic logic [BCD_W+BIN_W-1:0] dabble(input logic [BCD_W+BIN_W-1:0] s);
        logic [BCD_W+BIN_W-1:0] t;
        t = s;
        for (int n = 0; n < 3; n++) begin
            if (t[BIN_W+4*n +: 4] >= 4'd5)
                t[BIN_W+4*n +: 4] = t[BIN_W+4*n +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            sr_d  = dabble({{BCD_W{1'b0}}, bin});
            cnt_d = 3'd6;
        end else if (cnt_q != 3'd0) begin
            sr_d   = dabble(sr_q);
            cnt_d  = cnt_q - 3'd1;
            done_d = (cnt_q == 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign busy = (cnt_q != 3'd0);
    assign bcd  = sr_q[BCD_W+BIN_W-1:BIN_W];
    assign done = done_q;

endmodule

// File: rtl/placar_display_scan.sv
// Scoreboard display end: 16-clock convert/commit loop feeding a 6-digit scanned 7-seg.
// Define PLACAR_LZB_EN for per-team leading-zero blanking.
module placar_display_scan
    import placar_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [BIN_W-1:0] somaTime1,
    input  logic [BIN_W-1:0] somaTime2,
    output logic [6:0]       seg,
    output logic [5:0]       dig,
    output logic             upd_done
);

    state_t             state_q;
    logic [2:0]         step_q;
    logic [BIN_W-1:0]   hold1_q, hold2_q;
    logic [BCD_W-1:0]   tmp1_q, disp1_q, disp2_q;
    logic               upd_done_q;

    logic               cv_start, cv_busy, cv_done;
    logic [BIN_W-1:0]   cv_bin;
    logic [BCD_W-1:0]   cv_bcd;

    assign cv_start = (state_q == ST_CONV1 || state_q == ST_CONV2) && (step_q == 3'd0);
    assign cv_bin   = (state_q == ST_CONV1) ? hold1_q : hold2_q;

    placar_bin2bcd u_bin2bcd (
        .clk   (clock),
        .rst_n (clr),
        .start (cv_start),
        .bin   (cv_bin),
        .busy  (cv_busy),
        .bcd   (cv_bcd),
        .done  (cv_done)
    );

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            hold1_q    <= '0;
            hold2_q    <= '0;
            tmp1_q     <= '0;
            disp1_q    <= '0;
            disp2_q    <= '0;
            upd_done_q <= 1'b0;
        end else begin
            upd_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold1_q <= somaTime1;
                    hold2_q <= somaTime2;
                    step_q  <= '0;
                    state_q <= ST_CONV1;
                end
                ST_CONV1: begin
                    step_q <= (step_q == 3'd6) ? 3'd0 : step_q + 3'd1;
                    if (step_q == 3'd6) state_q <= ST_CONV2;
                end
                ST_CONV2: begin
                    // Team 1 result is valid only on the first CONV2 clock.
                    if (cv_done) tmp1_q <= cv_bcd;
                    step_q <= (step_q == 3'd6) ? 3'd0 : step_q + 3'd1;
                    if (step_q == 3'd6) state_q <= ST_COMMIT;
                end
                default: begin
                    disp1_q    <= tmp1_q;
                    disp2_q    <= cv_bcd;
                    upd_done_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [2:0]          idx_q, idx_d, next_idx, sel, pos;
    logic                lit_q, lit_d, tick, blank;
    logic [5:0]          dig_q, dig_d;
    logic [6:0]          seg_q, seg_d;
    logic [BCD_W-1:0]    team_bcd;
    logic [3:0]          nib;

    always_comb begin
        tick     = &presc_q;
        presc_d  = presc_q + 1'b1;
        next_idx = (lit_q && idx_q != 3'(NUM_DIGITS-1)) ? idx_q + 3'd1 : 3'd0;
        if (!lit_q) next_idx = 3'd0;
        sel      = tick ? next_idx : idx_q;
        idx_d    = sel;
        lit_d    = lit_q | tick;
        dig_d    = tick ? (6'(1) << next_idx) : dig_q;

        team_bcd = (sel >= 3'd3) ? disp2_q : disp1_q;
        pos      = (sel >= 3'd3) ? sel - 3'd3 : sel;
        case (pos)
            3'd0:    nib = team_bcd[3:0];
            3'd1:    nib = team_bcd[7:4];
            default: nib = team_bcd[11:8];
        endcase
`ifdef PLACAR_LZB_EN
        blank = (pos == 3'd2 && team_bcd[11:8] == 4'd0) ||
                (pos == 3'd1 && team_bcd[11:4] == 8'd0);
`else
        blank = 1'b0;
`endif
        // Segments refresh every clock so a commit shows up without waiting for a tick.
        seg_d = (lit_d && !blank) ? seg_of(nib) : SEG_BLANK;
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            presc_q <= '0;
            idx_q   <= '0;
            lit_q   <= 1'b0;
            dig_q   <= '0;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            lit_q   <= lit_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    assign seg      = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig      = SEG_ACTIVE_LOW ? ~dig_q : dig_q;
    assign upd_done = upd_done_q;

endmodule

// File: tb/tb_placar_display_scan.sv
// Directed bench for placar_display_scan: two instances (active-low and active-high) in lockstep.
module tb_placar_display_scan;

    logic       clock = 1'b0;
    logic       clr;
    logic [6:0] t1, t2;
    logic [6:0] seg_l, seg_h;
    logic [5:0] dig_l, dig_h;
    logic       upd_l, upd_h;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    placar_display_scan #(.SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
        .clock(clock), .clr(clr), .somaTime1(t1), .somaTime2(t2),
        .seg(seg_l), .dig(dig_l), .upd_done(upd_l)
    );

    placar_display_scan #(.SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b0)) u_dut_ah (
        .clock(clock), .clr(clr), .somaTime1(t1), .somaTime2(t2),
        .seg(seg_h), .dig(dig_h), .upd_done(upd_h)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            passed++;
    endtask

    function automatic int pat(input int d);
        case (d)
            0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
            4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
            8: return 'h7F;  9: return 'h6F;
            default: return 'h00;
        endcase
    endfunction

    task automatic wait_upd(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!upd_h && n < 40);
        if (!upd_h) n = 99;
    endtask

    task automatic read_all(input string tag, input int e[6]);
        for (int i = 0; i < 6; i++) begin
            int n = 0;
            while (dig_h !== 6'(1 << i) && n < 40) begin
                @(negedge clock);
                n++;
            end
            chk($sformatf("%s_dig%0d_found", tag, i), int'(dig_h), 1 << i);
            chk($sformatf("%s_seg%0d", tag, i), int'(seg_h), pat(e[i]));
            chk($sformatf("%s_pol%0d", tag, i), int'({dig_l, seg_l}), int'(~{dig_h, seg_h} & 13'h1FFF));
        end
    endtask

    initial begin
        int n;
        int e[6];
        logic [5:0] cur;
        int pulses, seen_dig, seen_seg;

        clr = 1'b0; t1 = '0; t2 = '0;
        repeat (3) @(negedge clock);
        chk("rst_dig_h", dig_h, 0);
        chk("rst_seg_h", seg_h, 0);
        chk("rst_dig_l", dig_l, 'h3F);
        chk("rst_seg_l", seg_l, 'h7F);
        chk("rst_upd",   upd_h, 0);

        clr = 1'b1;
        n = 0;
        while (dig_h == 6'd0 && n < 10) begin @(negedge clock); n++; end
        chk("first_tick_dig", dig_h, 1);
        chk("first_tick_seg", seg_h, pat(0));
        chk("first_tick_cycles", n, 4);

        t1 = 7'd42; t2 = 7'd7;
        wait_upd(n);
        chk("upd_latency_ok", int'(n <= 32), 1);
        wait_upd(n);
        chk("upd_period", n, 16);
`ifdef PLACAR_LZB_EN
        e = '{2, 4, -1, 7, -1, -1};
`else
        e = '{2, 4, 0, 7, 0, 0};
`endif
        read_all("s42_7", e);

        t1 = 7'd127; t2 = 7'd100;
        wait_upd(n);
        wait_upd(n);
        chk("bcd_127", int'(u_dut_ah.disp1_q), 'h127);
        chk("bcd_100", int'(u_dut_ah.disp2_q), 'h100);
        e = '{7, 2, 1, 0, 0, 1};
        read_all("s127_100", e);
        while (dig_h !== 6'b000100) @(negedge clock);
        chk("hundreds_one_bc", seg_h, 'h06);

        t1 = 7'd5; t2 = 7'd0;
        wait_upd(n);
        wait_upd(n);
        wait_upd(n);
        repeat (10) @(negedge clock);
        t1 = 7'd99;
        wait_upd(n);
        chk("conv2_change_old", int'(u_dut_ah.disp1_q), 'h005);
        wait_upd(n);
        chk("conv2_change_new", int'(u_dut_ah.disp1_q), 'h099);

        cur = dig_h;
        n = 0;
        while (dig_h == cur && n < 10) begin @(negedge clock); n++; end
        for (int k = 0; k < 7; k++) begin
            logic [5:0] want;
            cur  = dig_h;
            want = (cur == 6'b100000) ? 6'b000001 : cur << 1;
            chk($sformatf("scan_onehot%0d", k), int'($onehot(cur)), 1);
            n = 0;
            while (dig_h == cur && n < 10) begin @(negedge clock); n++; end
            chk($sformatf("scan_len%0d", k), n, 4);
            chk($sformatf("scan_next%0d", k), dig_h, want);
        end

        t1 = 7'd127; t2 = 7'd100;
        wait_upd(n);
        repeat (3) @(negedge clock);
        clr = 1'b0;
        #1;
        chk("midrst_dig_h", dig_h, 0);
        chk("midrst_seg_h", seg_h, 0);
        chk("midrst_dig_l", dig_l, 'h3F);
        chk("midrst_seg_l", seg_l, 'h7F);
        chk("midrst_disp", int'({u_dut_ah.disp1_q, u_dut_ah.disp2_q}), 0);
        pulses = 0;
        repeat (3) begin @(negedge clock); if (upd_h) pulses++; end
        clr = 1'b1;
        seen_dig = 0; seen_seg = -1;
        repeat (14) begin
            @(negedge clock);
            if (upd_h) pulses++;
            if (seen_dig == 0 && dig_h != 6'd0) begin
                seen_dig = dig_h;
                seen_seg = seg_h;
            end
        end
        chk("midrst_no_upd", pulses, 0);
        chk("midrst_first_dig", seen_dig, 1);
        chk("midrst_first_seg", seen_seg, pat(0));
        chk("midrst_disp_after", int'({u_dut_ah.disp1_q, u_dut_ah.disp2_q}), 0);
        wait_upd(n);
        chk("midrst_resume_upd", int'(n <= 32), 1);
        chk("midrst_resume_bcd", int'({u_dut_ah.disp1_q, u_dut_ah.disp2_q}), 'h127100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
